// File: rtl/fp_pkg.sv
// Shared types and constants for the FP adder back end (normalizer and rounder).
// Latency: none (types, constants and a combinational pack helper only).
// Backpressure: not applicable.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam int BIAS = 127;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SHIFT,
        S_ROUND,
        S_DONE
    } fsm_state_t;

    function automatic fp32_t pack_fp(input logic             sign,
                                      input logic [EXP_W-1:0] exp,
                                      input logic [MAN_W-1:0] frac);
        fp32_t r;
        r.sign = sign;
        r.exp  = exp;
        r.frac = frac;
        return r;
    endfunction

endpackage

// File: rtl/fp_rounder.sv
// Round-to-nearest-even of a packed exponent/fraction pair using guard, round and sticky bits.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller owns sequencing.
module fp_rounder
    import fp_pkg::*;
(
    input  logic [EXP_W-1:0] biased_exp,
    input  logic [MAN_W-1:0] frac,
    input  logic [2:0]       grs,
    output logic [EXP_W-1:0] rounded_exp,
    output logic [MAN_W-1:0] rounded_frac
);

    logic             round_up;
    logic [MAN_W:0]   frac_inc;

    // Round up above half, or on an exact tie when the LSB is odd; a fraction carry bumps the
    // exponent, which also turns a max subnormal into the min normal and 254 into Inf.
    always_comb begin
        round_up = grs[2] & (grs[1] | grs[0] | frac[0]);
        frac_inc = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
        if (frac_inc[MAN_W]) begin
            rounded_exp  = biased_exp + EXP_W'(1);
            rounded_frac = '0;
        end else begin
            rounded_exp  = biased_exp;
            rounded_frac = frac_inc[MAN_W-1:0];
        end
    end

endmodule

// File: rtl/fp_normalizer.sv
// Iterative post-add normalizer packing IEEE-754 single; FP_ROUND_NEAREST_EN adds an RNE ROUND state.
// Latency: 2 cycles (specials) up to 27 cycles (23 left shifts plus round); one operation in flight.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no accept on that cycle.
module fp_normalizer
    import fp_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [EXP_W-1:0]   in_exp,
    input  logic [MAN_W+1:0]   in_sum,
    input  logic [2:0]         in_grs,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_result,
    output logic [4:0]         out_cycles
);

    fsm_state_t        state_q;
    logic              sign_q;
    logic [EXP_W-1:0]  exp_q;
    logic [MAN_W+1:0]  sum_q;
    logic [31:0]       result_q;
    logic [4:0]        cycles_q;
    logic              out_valid_q;
    logic              in_ready_q;

    logic [EXP_W-1:0]  eff_exp;
    logic [EXP_W-1:0]  exp_inc;
    logic [EXP_W-1:0]  fin_exp;
    logic              shift_in;

`ifdef FP_ROUND_NEAREST_EN
    logic [2:0]        grs_q;
    logic [EXP_W-1:0]  rnd_exp;
    logic [MAN_W-1:0]  rnd_frac;

    fp_rounder u_rounder (
        .biased_exp   (exp_q),
        .frac         (sum_q[MAN_W-1:0]),
        .grs          (grs_q),
        .rounded_exp  (rnd_exp),
        .rounded_frac (rnd_frac)
    );

    assign shift_in = grs_q[2];
`else
    logic unused_grs;
    assign unused_grs = ^in_grs;
    assign shift_in   = 1'b0;
`endif

    // Exponent 0 scales like exponent 1; a stopped (unnormalized) result encodes exponent 0.
    always_comb begin
        eff_exp = (exp_q == '0) ? EXP_W'(1) : exp_q;
        exp_inc = eff_exp + EXP_W'(1);
        fin_exp = sum_q[MAN_W] ? eff_exp : '0;
    end

    // Control FSM and datapath: capture, classify, one shift per cycle, optional round, hold result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            sum_q       <= '0;
            result_q    <= '0;
            cycles_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef FP_ROUND_NEAREST_EN
            grs_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sign_q     <= in_sign;
                        exp_q      <= in_exp;
                        sum_q      <= in_sum;
                        cycles_q   <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_CHECK;
`ifdef FP_ROUND_NEAREST_EN
                        grs_q      <= in_grs;
`endif
                    end
                end
                S_CHECK: begin
                    if (exp_q == EXP_MAX) begin
                        result_q    <= pack_fp(sign_q, EXP_MAX, sum_q[MAN_W-1:0]);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (sum_q == '0) begin
                        result_q    <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        state_q     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (sum_q[MAN_W+1]) begin
                        sum_q    <= {1'b0, sum_q[MAN_W+1:1]};
                        exp_q    <= exp_inc;
                        cycles_q <= cycles_q + 5'd1;
`ifdef FP_ROUND_NEAREST_EN
                        grs_q    <= {sum_q[0], 1'b0, |grs_q};
`endif
                        if (exp_inc == EXP_MAX) begin
                            result_q    <= pack_fp(sign_q, EXP_MAX, '0);
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end else if (sum_q[MAN_W] || (exp_q <= EXP_W'(1))) begin
`ifdef FP_ROUND_NEAREST_EN
                        exp_q       <= fin_exp;
                        state_q     <= S_ROUND;
`else
                        result_q    <= pack_fp(sign_q, fin_exp, sum_q[MAN_W-1:0]);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
`endif
                    end else begin
                        sum_q    <= {sum_q[MAN_W:0], shift_in};
                        exp_q    <= exp_q - EXP_W'(1);
                        cycles_q <= cycles_q + 5'd1;
`ifdef FP_ROUND_NEAREST_EN
                        grs_q    <= {grs_q[1], grs_q[0], grs_q[0]};
`endif
                    end
                end
`ifdef FP_ROUND_NEAREST_EN
                S_ROUND: begin
                    result_q    <= pack_fp(sign_q, rnd_exp, rnd_frac);
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = result_q;
    assign out_cycles = cycles_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// Self-checking bench for fp_normalizer: vector table through a scoreboard queue plus handshake/reset sequences.
// Latency: checked per vector from accept edge to out_valid.
// Backpressure: exercised by holding out_ready low in DONE.
module tb_fp_normalizer;

`ifdef FP_ROUND_NEAREST_EN
    localparam bit RND_ON = 1'b1;
`else
    localparam bit RND_ON = 1'b0;
`endif
    localparam int NV = 19;
    localparam int LIMIT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [24:0] in_sum = '0;
    logic [2:0]  in_grs = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_cycles;

    fp_normalizer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_sum     (in_sum),
        .in_grs     (in_grs),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_cycles (out_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [24:0] sum;
        logic [2:0]  grs;
        logic [31:0] res_t;
        logic [31:0] res_r;
        logic [4:0]  cyc;
        logic [7:0]  lat;
        logic        rnd;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  cyc;
        logic [7:0]  lat;
        logic [7:0]  id;
    } exp_t;

    vec_t vecs [NV];
    exp_t exq [$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, req);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input vec_t v, input logic [7:0] id);
        int   n = 0;
        exp_t e;
        while (!in_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", id, {31'b0, in_ready}, 32'd1);
        in_sign  = v.sign;
        in_exp   = v.exp;
        in_sum   = v.sum;
        in_grs   = v.grs;
        in_valid = 1'b1;
        e.res = RND_ON ? v.res_r : v.res_t;
        e.cyc = v.cyc;
        e.lat = (v.lat == 8'd0) ? 8'd0 : v.lat + ((RND_ON && v.rnd) ? 8'd1 : 8'd0);
        e.id  = id;
        exq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic recv();
        int   n = 0;
        exp_t e;
        while (!out_valid && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (exq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty[0] actual=result_without_expectation required=queued_entry");
        end else begin
            e = exq.pop_front();
            if (!out_valid) begin
                checks++;
                failures++;
                $display("FAIL timeout[%0d] out_valid=0 required=1 within %0d cycles", e.id, LIMIT);
            end else begin
                chk("result", e.id, out_result, e.res);
                chk("cycles", e.id, {27'b0, out_cycles}, {27'b0, e.cyc});
                if (e.lat != 8'd0) chk("latency", e.id, 32'(n + 1), {24'b0, e.lat});
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog[0] actual=no_finish required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        int   spurious;
        vec_t a;
        exp_t eb;

        //            sign  exp    sum           grs     trunc         rne           cyc    lat   rnd
        vecs[0]  = '{1'b0, 8'h7F, 25'h1000000, 3'b000, 32'h40000000, 32'h40000000, 5'd1,  8'd4,  1'b1};
        vecs[1]  = '{1'b0, 8'h80, 25'h0000001, 3'b000, 32'h34800000, 32'h34800000, 5'd23, 8'd26, 1'b1};
        vecs[2]  = '{1'b0, 8'hFE, 25'h1000000, 3'b000, 32'h7F800000, 32'h7F800000, 5'd1,  8'd3,  1'b0};
        vecs[3]  = '{1'b1, 8'hFE, 25'h1000000, 3'b000, 32'hFF800000, 32'hFF800000, 5'd1,  8'd3,  1'b0};
        vecs[4]  = '{1'b0, 8'hFF, 25'h0400000, 3'b000, 32'h7FC00000, 32'h7FC00000, 5'd0,  8'd2,  1'b0};
        vecs[5]  = '{1'b1, 8'h42, 25'h0000000, 3'b000, 32'h00000000, 32'h00000000, 5'd0,  8'd2,  1'b0};
        vecs[6]  = '{1'b0, 8'h00, 25'h0800001, 3'b000, 32'h00800001, 32'h00800001, 5'd0,  8'd3,  1'b1};
        vecs[7]  = '{1'b0, 8'h7F, 25'h0FFFFFF, 3'b100, 32'h3FFFFFFF, 32'h40000000, 5'd0,  8'd3,  1'b1};
        vecs[8]  = '{1'b1, 8'hFF, 25'h0000001, 3'b000, 32'hFF800001, 32'hFF800001, 5'd0,  8'd2,  1'b0};
        vecs[9]  = '{1'b0, 8'h01, 25'h0400000, 3'b000, 32'h00400000, 32'h00400000, 5'd0,  8'd3,  1'b1};
        vecs[10] = '{1'b0, 8'h03, 25'h0100000, 3'b000, 32'h00400000, 32'h00400000, 5'd2,  8'd5,  1'b1};
        vecs[11] = '{1'b1, 8'h85, 25'h0200000, 3'b000, 32'hC1800000, 32'hC1800000, 5'd2,  8'd5,  1'b1};
        vecs[12] = '{1'b0, 8'h7F, 25'h1800000, 3'b000, 32'h40400000, 32'h40400000, 5'd1,  8'd4,  1'b1};
        vecs[13] = '{1'b0, 8'h7F, 25'h1000001, 3'b000, 32'h40000000, 32'h40000000, 5'd1,  8'd4,  1'b1};
        vecs[14] = '{1'b0, 8'h7F, 25'h1000003, 3'b000, 32'h40000001, 32'h40000002, 5'd1,  8'd4,  1'b1};
        vecs[15] = '{1'b0, 8'h00, 25'h07FFFFF, 3'b100, 32'h007FFFFF, 32'h00800000, 5'd0,  8'd3,  1'b1};
        vecs[16] = '{1'b0, 8'hFE, 25'h0FFFFFF, 3'b110, 32'h7F7FFFFF, 32'h7F800000, 5'd0,  8'd3,  1'b1};
        vecs[17] = '{1'b0, 8'h7F, 25'h0800000, 3'b011, 32'h3F800000, 32'h3F800000, 5'd0,  8'd3,  1'b1};
        vecs[18] = '{1'b0, 8'h7F, 25'h0800000, 3'b101, 32'h3F800000, 32'h3F800001, 5'd0,  8'd3,  1'b1};

        // Reset state, during and just after reset.
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 0, {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", 0, {31'b0, out_valid}, 32'd0);
        chk("rst_result", 0, out_result, 32'd0);
        chk("rst_cycles", 0, {27'b0, out_cycles}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 0, {31'b0, in_ready}, 32'd1);
        chk("idle_out_valid", 0, {31'b0, out_valid}, 32'd0);

        // Table-driven vectors.
        for (int i = 0; i < NV; i++) begin
            send(vecs[i], 8'(i));
            recv();
        end

        // Backpressure: hold out_ready low for 5 cycles in DONE while a second operand waits.
        out_ready = 1'b0;
        a = vecs[0];
        a.lat = 8'd0;
        send(a, 8'd100);
        n = 0;
        while (!out_valid && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", 100, {31'b0, out_valid}, 32'd1);
        in_sign  = 1'b1;
        in_exp   = 8'h80;
        in_sum   = 25'h0800000;
        in_grs   = 3'b000;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", k, {31'b0, out_valid}, 32'd1);
            chk("bp_hold", k, out_result, vecs[0].res_t);
            chk("bp_in_ready", k, {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        recv();
        chk("hs_out_valid", 101, {31'b0, out_valid}, 32'd0);
        chk("hs_in_ready", 101, {31'b0, in_ready}, 32'd1);
        eb.res = 32'hC0000000;
        eb.cyc = 5'd0;
        eb.lat = 8'd0;
        eb.id  = 8'd101;
        exq.push_back(eb);
        @(negedge clk);
        in_valid = 1'b0;
        recv();

        // Asynchronous reset in the middle of a long left-shift run.
        send(vecs[1], 8'd102);
        repeat (5) @(negedge clk);
        chk("mid_cycles", 102, {27'b0, out_cycles}, 32'd4);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 102, {31'b0, out_valid}, 32'd0);
        chk("arst_in_ready", 102, {31'b0, in_ready}, 32'd1);
        chk("arst_cycles", 102, {27'b0, out_cycles}, 32'd0);
        chk("arst_result", 102, out_result, 32'd0);
        exq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        chk("no_partial", 102, 32'(spurious), 32'd0);
        send(vecs[11], 8'd103);
        recv();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
